pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 110 +++++++++++
 tb/tb_pc_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
//==============================================================================
// Module   : pc_unit
// Purpose  : Program counter with branch/jump redirect, stall hold and a sticky
//            misaligned-redirect trap. Define PC_UNIT_DELAY_SLOT_EN for one
//            MIPS branch delay slot.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        fetch_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        align_err
);

   typedef enum logic [0:0] {
      NORMAL  = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        err_q, err_d;
   logic        live_q;

   logic        w_adv;
   logic        w_redirect;
   logic        w_misaligned;
   logic [31:0] w_jump_tgt;
   logic [31:0] w_target;

   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign align_err   = err_q;
   // live_q is low for exactly one cycle after any edge that sampled reset.
   assign fetch_valid = live_q & ~err_q;
   assign w_adv       = fetch_valid & fetch_ready & ~stall;
   assign w_jump_tgt  = {pc_plus4[31:28], jump_index, 2'b00};

   always_comb begin
      w_redirect   = jump | pc_src;
      w_target     = jump ? w_jump_tgt : branch_target;
      w_misaligned = w_redirect && (w_target[1:0] != 2'b00);
   end

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      tgt_d   = tgt_q;
      err_d   = err_q;
`ifdef PC_UNIT_DELAY_SLOT_EN
      if (w_adv) begin
         // Redirects seen in the delay slot itself are dropped.
         if (state_q == PENDING) begin
            pc_d    = tgt_q;
            state_d = NORMAL;
         end else if (w_misaligned) begin
            err_d = 1'b1;
         end else if (w_redirect) begin
            pc_d    = pc_plus4;
            tgt_d   = w_target;
            state_d = PENDING;
         end else begin
            pc_d = pc_plus4;
         end
      end
`else
      if (w_adv) begin
         if (w_misaligned) begin
            err_d = 1'b1;
         end else if (w_redirect) begin
            pc_d = w_target;
         end else begin
            pc_d = pc_plus4;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         state_q <= NORMAL;
         tgt_q   <= 32'h0000_0000;
         err_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         tgt_q   <= tgt_d;
         err_q   <= err_d;
         live_q  <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//==============================================================================
// Module   : tb_pc_unit
// Purpose  : Directed self-checking bench for pc_unit (either delay-slot build).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_unit;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        pc_src;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic        fetch_ready;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        align_err;

   int n_checks = 0;
   int n_errors = 0;

   pc_unit #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_index    (jump_index),
      .fetch_ready   (fetch_ready),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .fetch_valid   (fetch_valid),
      .align_err     (align_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Branch to an aligned target; in the delay-slot build also retire the slot.
   task automatic go_to(input logic [31:0] t);
      pc_src        = 1'b1;
      branch_target = t;
      tick();
      pc_src        = 1'b0;
`ifdef PC_UNIT_DELAY_SLOT_EN
      tick();
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; pc_src = 1'b0; branch_target = '0;
      jump = 1'b0; jump_index = '0; fetch_ready = 1'b1;

      // Reset and sequential fetch
      tick();
      check("rst_pc", pc, RESET_PC);
      check("rst_fv", {31'b0, fetch_valid}, 32'd0);
      check("rst_err", {31'b0, align_err}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("first_pc", pc, 32'h0040_0000);
      check("first_fv", {31'b0, fetch_valid}, 32'd1);
      check("first_p4", pc_plus4, 32'h0040_0004);
      tick();
      check("seq1", pc, 32'h0040_0004);
      tick();
      check("seq2", pc, 32'h0040_0008);
      tick();
      check("seq3", pc, 32'h0040_000C);
      tick();
      check("seq4", pc, 32'h0040_0010);

      // Taken branch from 0x00400010
      pc_src = 1'b1; branch_target = 32'h0040_0040;
      tick();
`ifdef PC_UNIT_DELAY_SLOT_EN
      check("br_slot", pc, 32'h0040_0014);
      // Branch in the delay slot with a 3-cycle stall: both must be ignored/held
      branch_target = 32'h0040_0080;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("slot_stall", pc, 32'h0040_0014);
      end
      stall = 1'b0;
      tick();
      pc_src = 1'b0;
      check("br_target", pc, 32'h0040_0040);
`else
      pc_src = 1'b0;
      check("br_target", pc, 32'h0040_0040);
`endif

      // Hold on stall and on fetch not ready
      stall = 1'b1;
      tick();
      check("stall_hold", pc, 32'h0040_0040);
      stall = 1'b0; fetch_ready = 1'b0;
      tick();
      check("nready_hold", pc, 32'h0040_0040);
      fetch_ready = 1'b1;
      tick();
      check("resume", pc, 32'h0040_0044);

      // Jump beats a simultaneous branch
      go_to(32'h1000_0000);
      check("at_1000", pc, 32'h1000_0000);
      jump = 1'b1; jump_index = 26'h000_0100;
      pc_src = 1'b1; branch_target = 32'h0040_0040;
      tick();
      jump = 1'b0; pc_src = 1'b0;
`ifdef PC_UNIT_DELAY_SLOT_EN
      check("jmp_slot", pc, 32'h1000_0004);
      tick();
`endif
      check("jmp_wins", pc, 32'h1000_0400);

      // Wrap at the top of the address space
      go_to(32'hFFFF_FFFC);
      check("top_pc", pc, 32'hFFFF_FFFC);
      check("top_p4", pc_plus4, 32'h0000_0000);
      tick();
      check("wrap_pc", pc, 32'h0000_0000);
      check("wrap_err", {31'b0, align_err}, 32'd0);

      // Reset with a redirect in flight (PENDING in the delay-slot build)
      pc_src = 1'b1; branch_target = 32'h0040_0100;
      tick();
      pc_src = 1'b0;
      rst_n = 1'b0;
      tick();
      check("rst2_pc", pc, RESET_PC);
      rst_n = 1'b1;
      tick();
      check("rst2_hold", pc, RESET_PC);
      tick();
      check("rst2_seq", pc, 32'h0040_0004);

      // Misaligned branch target traps
      pc_src = 1'b1; branch_target = 32'h0040_0042;
      tick();
      pc_src = 1'b0;
      check("mis_pc", pc, 32'h0040_0004);
      check("mis_err", {31'b0, align_err}, 32'd1);
      check("mis_fv", {31'b0, fetch_valid}, 32'd0);
      tick();
      tick();
      check("mis_pc_held", pc, 32'h0040_0004);
      check("mis_err_sticky", {31'b0, align_err}, 32'd1);
      rst_n = 1'b0;
      tick();
      check("mis_rst_err", {31'b0, align_err}, 32'd0);
      check("mis_rst_fv", {31'b0, fetch_valid}, 32'd0);
      check("mis_rst_pc", pc, RESET_PC);
      rst_n = 1'b1;
      tick();
      check("mis_rec_fv", {31'b0, fetch_valid}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
